// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the memory stage.
// Data accesses win ties, with a bounded burst so a waiting fetch is never starved.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DM_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic              i_dm_word,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_ready,
  output logic [DATA_W-1:0] o_dm_rdata,
  input  logic              i_flush,
  output logic              o_stall_fetch,
  output logic              o_stall_mem,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic              o_mem_word,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned CntW = $clog2(MAX_DM_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_DM_BURST);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy, StIfDrop} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_burst_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_mem_word;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_grant_dm;
  logic w_grant_if;

  assign w_grant_dm = i_dm_req & ((r_burst_cnt < CntMax) | ~i_if_req);
  assign w_grant_if = ~w_grant_dm & i_if_req & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_burst_cnt <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_word  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant_dm) begin
            r_state     <= StDmBusy;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_dm_we;
            r_mem_word  <= i_dm_word;
            r_mem_addr  <= i_dm_addr;
            r_mem_wdata <= i_dm_wdata;
            // Only consecutive data grants that overtake a waiting fetch count
            if (!i_if_req)                 r_burst_cnt <= '0;
            else if (r_burst_cnt < CntMax) r_burst_cnt <= r_burst_cnt + 1'b1;
          end else if (w_grant_if) begin
            r_state     <= StIfBusy;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_word  <= 1'b1;
            r_mem_addr  <= i_if_addr;
            r_mem_wdata <= '0;
            r_burst_cnt <= '0;
          end
        end
        StIfBusy, StDmBusy, StIfDrop: begin
          if (i_mem_ack) begin
            r_state     <= StIdle;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_word  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
          end else if (r_state == StIfBusy && i_flush) begin
            // Memory still owes an ack; drain it without reporting it
            r_state <= StIfDrop;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_if_ready    = (r_state == StIfBusy) & i_mem_ack & ~i_flush;
  assign o_if_rdata    = o_if_ready ? i_mem_rdata : '0;
  assign o_dm_ready    = (r_state == StDmBusy) & i_mem_ack;
  assign o_dm_rdata    = (o_dm_ready & ~r_mem_we) ? i_mem_rdata : '0;
  assign o_stall_fetch = i_if_req & ~o_if_ready;
  assign o_stall_mem   = i_dm_req & ~o_dm_ready;

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_word  = r_mem_word;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
